ws_os_pe_driver: RTL and testbench

- Initiator-side sequencer for one ws_os_pe processing element.
- Takes a tile command (mode, reduction length, WS weight) and an operand stream, and generates the PE pin protocol: load_w pulse, valid_in beats, and the OS-mode b-ahead-of-a skew.
- Reads back accum_out and returns one 2*DW dot-product result per command over a valid/ready handshake.
- Sits between the array tile controller and each PE column/row.

---
 rtl/ws_os_pe_driver.sv | 178 +++++++++++++++++
 tb/tb_ws_os_pe_driver.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_os_pe_driver.sv
// Initiator-side sequencer for a single ws_os_pe: turns a tile command plus an
// operand stream into PE pin activity and returns one dot-product result per tile.
module ws_os_pe_driver #(
   parameter int DW   = 16,
   parameter int KMAX = 64,
   parameter int KW   = $clog2(KMAX + 1)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic            cmd_mode,
   input  logic [KW-1:0]   cmd_len,
   input  logic [DW-1:0]   cmd_weight,
   input  logic            op_valid,
   output logic            op_ready,
   input  logic [DW-1:0]   op_a,
   input  logic [DW-1:0]   op_b,
   output logic            pe_mode,
   output logic            pe_load_w,
   output logic [DW-1:0]   pe_w_in,
   output logic            pe_valid_in,
   output logic [DW-1:0]   pe_a_in,
   output logic [DW-1:0]   pe_b_in,
   input  logic [2*DW-1:0] pe_accum_out,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [2*DW-1:0] res_data,
   output logic            busy
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LOAD    = 3'd1,
      ST_STREAM  = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_CAPTURE = 3'd5,
      ST_RESULT  = 3'd6
   } state_t;

   localparam logic [KW-1:0] KMAX_K = KW'(KMAX);
   localparam logic [KW-1:0] ONE_K  = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [KW-1:0] ZERO_K = {KW{1'b0}};

   state_t            state_r;
   logic [KW-1:0]     k_r;
   logic [KW-1:0]     cnt_r;
   logic [DW-1:0]     a_dly_r;
   logic [2*DW-1:0]   base_r;

   logic [KW-1:0]     k_sel_s;
   logic [KW-1:0]     cnt_next_s;
   logic              op_hs_s;
   logic              last_beat_s;

   assign op_hs_s     = op_valid & op_ready;
   assign cnt_next_s  = cnt_r + ONE_K;
   assign last_beat_s = (cnt_next_s == k_r);

   // Clamp the requested reduction length to KMAX.
   always_comb begin
      k_sel_s = cmd_len;
      if (cmd_len > KMAX_K) begin
         k_sel_s = KMAX_K;
      end else begin
         k_sel_s = cmd_len;
      end
   end

   // Tile sequencer; every output is a flop updated here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         k_r         <= ZERO_K;
         cnt_r       <= ZERO_K;
         a_dly_r     <= {DW{1'b0}};
         base_r      <= {(2*DW){1'b0}};
         cmd_ready   <= 1'b1;
         op_ready    <= 1'b0;
         busy        <= 1'b0;
         pe_mode     <= 1'b0;
         pe_load_w   <= 1'b0;
         pe_w_in     <= {DW{1'b0}};
         pe_valid_in <= 1'b0;
         pe_a_in     <= {DW{1'b0}};
         pe_b_in     <= {DW{1'b0}};
         res_valid   <= 1'b0;
         res_data    <= {(2*DW){1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  busy      <= 1'b1;
                  pe_mode   <= cmd_mode;
                  k_r       <= k_sel_s;
                  cnt_r     <= ZERO_K;
                  a_dly_r   <= {DW{1'b0}};
                  // The PE is idle here, so its accumulator is a stable OS baseline.
                  base_r    <= cmd_mode ? pe_accum_out : {(2*DW){1'b0}};
                  if (k_sel_s == ZERO_K) begin
                     res_data  <= {(2*DW){1'b0}};
                     res_valid <= 1'b1;
                     state_r   <= ST_RESULT;
                  end else if (cmd_mode) begin
                     op_ready  <= 1'b1;
                     state_r   <= ST_STREAM;
                  end else begin
                     op_ready  <= 1'b1;
                     pe_load_w <= 1'b1;
                     pe_w_in   <= cmd_weight;
                     state_r   <= ST_LOAD;
                  end
               end
            end
            ST_LOAD, ST_STREAM: begin
               pe_load_w <= 1'b0;
               if (op_hs_s) begin
                  pe_valid_in <= 1'b1;
                  cnt_r       <= cnt_next_s;
                  // OS pins carry a one-beat-late a against the current b.
                  if (pe_mode) begin
                     pe_a_in <= a_dly_r;
                     pe_b_in <= op_b;
                     a_dly_r <= op_a;
                  end else begin
                     pe_a_in <= op_a;
                     pe_b_in <= {DW{1'b0}};
                  end
                  if (last_beat_s) begin
                     op_ready <= 1'b0;
                     state_r  <= pe_mode ? ST_FLUSH : ST_DRAIN;
                  end else begin
                     state_r  <= ST_STREAM;
                  end
               end else begin
                  pe_valid_in <= 1'b0;
                  state_r     <= ST_STREAM;
               end
            end
            ST_FLUSH: begin
               pe_valid_in <= 1'b1;
               pe_a_in     <= a_dly_r;
               pe_b_in     <= {DW{1'b0}};
               state_r     <= ST_DRAIN;
            end
            ST_DRAIN: begin
               pe_valid_in <= 1'b0;
               state_r     <= ST_CAPTURE;
            end
            ST_CAPTURE: begin
               res_data  <= pe_accum_out - base_r;
               res_valid <= 1'b1;
               state_r   <= ST_RESULT;
            end
            ST_RESULT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  busy      <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               cmd_ready   <= 1'b1;
               op_ready    <= 1'b0;
               busy        <= 1'b0;
               pe_load_w   <= 1'b0;
               pe_valid_in <= 1'b0;
               res_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ws_os_pe_driver.sv
// Bench for ws_os_pe_driver: a behavioural PE model closes the loop, pin beats
// and tile results are checked against scoreboard queues filled at stimulus time.
module tb_ws_os_pe_driver;

   localparam int DW   = 16;
   localparam int KMAX = 64;
   localparam int KW   = $clog2(KMAX + 1);

   logic            clk = 1'b0;
   logic            rst_n;
   logic            cmd_valid, cmd_ready, cmd_mode;
   logic [KW-1:0]   cmd_len;
   logic [DW-1:0]   cmd_weight;
   logic            op_valid, op_ready;
   logic [DW-1:0]   op_a, op_b;
   logic            pe_mode, pe_load_w, pe_valid_in;
   logic [DW-1:0]   pe_w_in, pe_a_in, pe_b_in;
   logic [2*DW-1:0] pe_accum_out;
   logic            res_valid, res_ready, busy;
   logic [2*DW-1:0] res_data;

   ws_os_pe_driver #(.DW(DW), .KMAX(KMAX)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
      .cmd_len(cmd_len), .cmd_weight(cmd_weight),
      .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
      .pe_mode(pe_mode), .pe_load_w(pe_load_w), .pe_w_in(pe_w_in),
      .pe_valid_in(pe_valid_in), .pe_a_in(pe_a_in), .pe_b_in(pe_b_in),
      .pe_accum_out(pe_accum_out),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural PE: WS multiplies by the loaded weight, OS by the previously registered b.
   logic [2*DW-1:0] pe_acc = '0;
   logic [DW-1:0]   pe_w = '0;
   logic [DW-1:0]   pe_b_r = '0;
   logic            preset = 1'b0;
   logic [2*DW-1:0] preset_val = '0;
   assign pe_accum_out = pe_acc;

   always @(posedge clk) begin
      if (preset) begin
         pe_acc <= preset_val;
      end else if (pe_load_w) begin
         pe_w   <= pe_w_in;
         pe_acc <= '0;
      end else if (pe_valid_in) begin
         if (pe_mode) begin
            pe_acc <= pe_acc + (2*DW)'(pe_a_in) * (2*DW)'(pe_b_r);
            pe_b_r <= pe_b_in;
         end else begin
            pe_acc <= pe_acc + (2*DW)'(pe_a_in) * (2*DW)'(pe_w);
         end
      end
   end

   typedef struct {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      int            cyc;
   } beat_t;

   beat_t           beat_q[$];
   logic [2*DW-1:0] res_q[$];
   int n_tests = 0;
   int n_fail  = 0;
   int load_cnt = 0;
   int valid_cnt = 0;
   int last_load_cyc = -1;

   logic [DW-1:0] a_arr[128];
   logic [DW-1:0] b_arr[128];
   bit            stall_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Pin monitor: every valid_in beat must match the next expected beat, in the expected cycle.
   always @(negedge clk) begin : mon
      beat_t e;
      if (pe_load_w) begin
         load_cnt++;
         last_load_cyc = cyc;
      end
      if (pe_valid_in) begin
         valid_cnt++;
         if (beat_q.size() == 0) begin
            check_val("unexpected_valid_in", 64'd1, 64'd0);
         end else begin
            e = beat_q.pop_front();
            check_val("beat_a", 64'(pe_a_in), 64'(e.a));
            check_val("beat_b", 64'(pe_b_in), 64'(e.b));
            check_val("beat_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
   end

   task automatic run_tile(input logic mode, input int len, input logic [DW-1:0] w,
                           input bit stall, input int rr_hold, input bit chk_lat);
      int k, i, guard, pidx, t0, ld0, vd0, last_hs, lat;
      logic [2*DW-1:0] exp_r;
      logic [DW-1:0] prev_a;
      logic v;
      k = (len > KMAX) ? KMAX : len;
      exp_r = '0;
      for (int j = 0; j < k; j++) begin
         if (mode) exp_r += (2*DW)'(a_arr[j]) * (2*DW)'(b_arr[j]);
         else      exp_r += (2*DW)'(a_arr[j]) * (2*DW)'(w);
      end
      res_q.push_back(exp_r);
      ld0 = load_cnt;
      vd0 = valid_cnt;
      guard = 0;
      @(negedge clk);
      while (!cmd_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_val("cmd_ready_wait", 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_mode = mode; cmd_len = KW'(len); cmd_weight = w;
      t0 = cyc;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      i = 0; guard = 0; pidx = 0; prev_a = '0; last_hs = t0;
      while (i < k && guard < 1000) begin
         @(negedge clk);
         guard++;
         v = stall ? stall_pat[pidx % 7] : 1'b1;
         pidx++;
         op_valid = v; op_a = a_arr[i]; op_b = b_arr[i];
         if (v && op_ready) begin
            if (mode) beat_q.push_back('{a: prev_a, b: b_arr[i], cyc: cyc + 1});
            else      beat_q.push_back('{a: a_arr[i], b: '0, cyc: cyc + 1});
            prev_a = a_arr[i];
            last_hs = cyc;
            i++;
         end
         @(posedge clk);
      end
      #1 op_valid = 1'b0;
      check_val("ops_accepted", 64'(i), 64'(k));
      if (mode && k > 0) beat_q.push_back('{a: prev_a, b: '0, cyc: last_hs + 2});
      @(negedge clk);
      check_val("op_ready_after", 64'(op_ready), 64'd0);
      guard = 0;
      while (!res_valid && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      check_val("res_valid_wait", 64'(res_valid), 64'd1);
      if (chk_lat) begin
         lat = (k == 0) ? 1 : (mode ? k + 4 : k + 3);
         check_val("res_latency", 64'(cyc - t0), 64'(lat));
      end
      for (int j = 0; j < rr_hold; j++) begin
         check_val("hold_res_data", 64'(res_data), 64'(res_q[0]));
         check_val("hold_cmd_ready", 64'(cmd_ready), 64'd0);
         @(negedge clk);
      end
      res_ready = 1'b1;
      check_val("res_data", 64'(res_data), 64'(res_q.pop_front()));
      check_val("busy_in_result", 64'(busy), 64'd1);
      @(posedge clk);
      #1 res_ready = 1'b0;
      @(negedge clk);
      check_val("post_cmd_ready", 64'({cmd_ready, res_valid, busy}), 64'b100);
      check_val("load_w_pulses", 64'(load_cnt - ld0), 64'((!mode && k > 0) ? 1 : 0));
      check_val("valid_in_pulses", 64'(valid_cnt - vd0), 64'((k == 0) ? 0 : (mode ? k + 1 : k)));
      if (!mode && k > 0) check_val("load_w_cycle", 64'(last_load_cyc), 64'(t0 + 1));
      check_val("beats_drained", 64'(beat_q.size()), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] prev_a;
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_len = '0; cmd_weight = '0;
      op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_res_data", 64'(res_data), 64'd0);
      check_val("rst_pins", 64'({pe_w_in, pe_a_in, pe_b_in}), 64'd0);
      check_val("rst_ctrl", 64'({cmd_ready, op_ready, pe_mode, pe_load_w, pe_valid_in, res_valid, busy}),
                64'b1000000);
      rst_n = 1'b1;

      for (int j = 0; j < 4; j++) begin a_arr[j] = DW'(j + 1); b_arr[j] = DW'(j + 5); end
      run_tile(1'b0, 4, 16'd3, 1'b0, 0, 1'b1);        // 30
      run_tile(1'b1, 4, 16'd0, 1'b0, 0, 1'b1);        // 70
      a_arr[0] = 16'd2; a_arr[1] = 16'd2; b_arr[0] = 16'd3; b_arr[1] = 16'd3;
      run_tile(1'b1, 2, 16'd0, 1'b0, 2, 1'b1);        // 12
      a_arr[0] = 16'hFFFF; a_arr[1] = 16'hFFFF;
      run_tile(1'b0, 2, 16'hFFFF, 1'b0, 0, 1'b1);     // 0xFFFC0002

      @(negedge clk);
      preset_val = 32'hFFFF_FFF0; preset = 1'b1;
      @(posedge clk);
      #1 preset = 1'b0;
      a_arr[0] = 16'd4; b_arr[0] = 16'd8;
      run_tile(1'b1, 1, 16'd0, 1'b0, 0, 1'b1);        // 0x20 across the wrap

      for (int j = 0; j < 4; j++) a_arr[j] = DW'(j + 1);
      run_tile(1'b0, 4, 16'd3, 1'b1, 5, 1'b0);        // stalled operands, held result

      run_tile(1'b0, 0, 16'd9, 1'b0, 0, 1'b1);
      run_tile(1'b1, 0, 16'd0, 1'b0, 0, 1'b1);
      for (int j = 0; j < 128; j++) begin a_arr[j] = DW'(j + 1); b_arr[j] = DW'(2); end
      run_tile(1'b0, KMAX + 3, 16'd1, 1'b0, 0, 1'b1);
      run_tile(1'b1, KMAX + 3, 16'd0, 1'b0, 0, 1'b1);

      // Abort an OS tile mid-stream with a one-cycle reset.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_mode = 1'b1; cmd_len = KW'(4); cmd_weight = '0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      prev_a = '0;
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         op_valid = 1'b1; op_a = DW'(j + 1); op_b = DW'(j + 1);
         check_val("rst_op_ready", 64'(op_ready), 64'd1);
         beat_q.push_back('{a: prev_a, b: DW'(j + 1), cyc: cyc + 1});
         prev_a = DW'(j + 1);
         @(posedge clk);
      end
      #1 op_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_val("abort_res_data", 64'(res_data), 64'd0);
      check_val("abort_pins", 64'({pe_w_in, pe_a_in, pe_b_in}), 64'd0);
      check_val("abort_ctrl", 64'({cmd_ready, op_ready, pe_mode, pe_load_w, pe_valid_in, res_valid, busy}),
                64'b1000000);
      check_val("abort_beats", 64'(beat_q.size()), 64'd0);
      a_arr[0] = 16'd5;
      run_tile(1'b0, 1, 16'd2, 1'b0, 0, 1'b1);        // 10

      for (int r = 0; r < 6; r++) begin
         bit st;
         st = 1'($urandom_range(0, 1));
         for (int j = 0; j < 8; j++) begin a_arr[j] = DW'($urandom); b_arr[j] = DW'($urandom); end
         run_tile(1'($urandom_range(0, 1)), $urandom_range(1, 8), DW'($urandom), st,
                  $urandom_range(0, 3), !st);
      end

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
